// File: rtl/jtmx5k_sdram_sched.sv
// -----------------------------------------------------------------------------
// jtmx5k_sdram_sched
//   Round-robin scheduler that shares one SDRAM read port among four ROM
//   clients of the MX5000 core: GFX1 (slot 0), ADPCM A (slot 1), ADPCM B
//   (slot 2) and the sound CPU (slot 3). Each slot keeps a one-word cache
//   (tag + data), so a repeated read of the same address is answered without
//   SDRAM traffic.
//
// Ports
//   clk, rst_n        SDRAM clock (rising edge), asynchronous active-low reset
//   downloading       ROM download in progress: flushes caches, holds off requests
//   slotN_cs          client read request (level), N = 0..3
//   slotN_addr        client word address, SLOT_AW bits
//   slotN_ok          slotN_dout is valid for the current slotN_addr
//   slotN_dout        cached 16-bit word for slot N
//   sdram_req         read request to the SDRAM controller
//   sdram_addr        22-bit word address = SLOTn_OFFSET + zero-extended address
//   sdram_ack         controller accepted the request
//   data_dst          data phase starting (monitored only)
//   data_rdy          data_read valid, single-cycle pulse
//   data_read         SDRAM read word
// -----------------------------------------------------------------------------
module jtmx5k_sdram_sched #(
    parameter int          SLOT_AW      = 18,
    parameter logic [21:0] SLOT0_OFFSET = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET = 22'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic               slot0_cs,
    input  logic [SLOT_AW-1:0] slot0_addr,
    output logic               slot0_ok,
    output logic [15:0]        slot0_dout,
    input  logic               slot1_cs,
    input  logic [SLOT_AW-1:0] slot1_addr,
    output logic               slot1_ok,
    output logic [15:0]        slot1_dout,
    input  logic               slot2_cs,
    input  logic [SLOT_AW-1:0] slot2_addr,
    output logic               slot2_ok,
    output logic [15:0]        slot2_dout,
    input  logic               slot3_cs,
    input  logic [SLOT_AW-1:0] slot3_addr,
    output logic               slot3_ok,
    output logic [15:0]        slot3_dout,
    output logic               sdram_req,
    output logic [21:0]        sdram_addr,
    input  logic               sdram_ack,
    input  logic               data_dst,
    input  logic               data_rdy,
    input  logic [15:0]        data_read
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state, state_nx;
    logic [3:0]         cs, hit, pending, valid;
    logic [SLOT_AW-1:0] addr [4];
    logic [SLOT_AW-1:0] tag  [4];
    logic [15:0]        data [4];
    logic [1:0]         rr, gnt, cand, pick;
    logic               pick_any;
    logic [21:0]        pick_offset, pick_sdram;
    logic [SLOT_AW-1:0] lat_addr;

    // data_dst carries no information this scheduler needs; data_rdy alone
    // closes the transaction.
    logic unused_dst;
    assign unused_dst = data_dst;

    assign cs      = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;

    // Hit is combinational from the registered cache so a client sees ok in
    // the same cycle it presents an address already held in its slot.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, otherwise a latch is inferred.
        hit = '0;
        for (int i = 0; i < 4; i++)
            hit[i] = cs[i] & valid[i] & (tag[i] == addr[i]);
        pending = cs & ~hit;
    end

    // Scan rr+1, rr+2, rr+3, rr: the slot served last has the lowest priority.
    always_comb begin
        pick_any = 1'b0;
        pick     = rr;
        cand     = rr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr + 2'(k);
            if (!pick_any && pending[cand]) begin
                pick_any = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        pick_offset = SLOT0_OFFSET;
        case (pick)
            2'd0:    pick_offset = SLOT0_OFFSET;
            2'd1:    pick_offset = SLOT1_OFFSET;
            2'd2:    pick_offset = SLOT2_OFFSET;
            default: pick_offset = SLOT3_OFFSET;
        endcase
        // 22-bit modulo sum; carries out of bit 21 are dropped.
        pick_sdram = pick_offset + 22'(addr[pick]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; downloading forces IDLE every cycle it is high.
    always_comb begin
        state_nx = state;
        if (downloading) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (pick_any)  state_nx = REQ;
                REQ:     if (sdram_ack) state_nx = WAIT;
                WAIT:    if (data_rdy)  state_nx = IDLE;
                default:                state_nx = IDLE;
            endcase
        end
    end

    // Grant latch, request address, round-robin pointer and the slot caches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt        <= 2'd0;
            lat_addr   <= '0;
            sdram_addr <= 22'd0;
            rr         <= 2'd3;
            valid      <= '0;
            // NOTE: the four-entry cache is plain flops, so it is reset to give a defined dout after reset.
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                data[i] <= 16'd0;
            end
        end else if (downloading) begin
            valid <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt        <= pick;
                lat_addr   <= addr[pick];
                sdram_addr <= pick_sdram;
            end
            // The word is tagged with the address latched at grant time, even
            // if the client has since moved on; a mismatch simply re-misses.
            if (state == WAIT && data_rdy) begin
                data[gnt]  <= data_read;
                tag[gnt]   <= lat_addr;
                valid[gnt] <= 1'b1;
                rr         <= gnt;
            end
        end
    end

    // Outputs
    always_comb begin
        sdram_req  = (state == REQ);
        slot0_ok   = hit[0];
        slot1_ok   = hit[1];
        slot2_ok   = hit[2];
        slot3_ok   = hit[3];
        slot0_dout = data[0];
        slot1_dout = data[1];
        slot2_dout = data[2];
        slot3_dout = data[3];
    end

endmodule

// File: tb/tb_jtmx5k_sdram_sched.sv
module tb_jtmx5k_sdram_sched;

    localparam logic [21:0] OFF0 = 22'h000000;
    localparam logic [21:0] OFF1 = 22'h040000;
    localparam logic [21:0] OFF2 = 22'h3F0000;
    localparam logic [21:0] OFF3 = 22'h010000;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [3:0]  cs_v;
    logic [17:0] addr_v [4];
    logic [3:0]  ok_v;
    logic [15:0] dout_v [4];
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [15:0] data_read;

    jtmx5k_sdram_sched #(
        .SLOT_AW     (18),
        .SLOT0_OFFSET(OFF0),
        .SLOT1_OFFSET(OFF1),
        .SLOT2_OFFSET(OFF2),
        .SLOT3_OFFSET(OFF3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .downloading(downloading),
        .slot0_cs   (cs_v[0]),
        .slot0_addr (addr_v[0]),
        .slot0_ok   (ok_v[0]),
        .slot0_dout (dout_v[0]),
        .slot1_cs   (cs_v[1]),
        .slot1_addr (addr_v[1]),
        .slot1_ok   (ok_v[1]),
        .slot1_dout (dout_v[1]),
        .slot2_cs   (cs_v[2]),
        .slot2_addr (addr_v[2]),
        .slot2_ok   (ok_v[2]),
        .slot2_dout (dout_v[2]),
        .slot3_cs   (cs_v[3]),
        .slot3_addr (addr_v[3]),
        .slot3_ok   (ok_v[3]),
        .slot3_dout (dout_v[3]),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // One word per slot, plus at most one outstanding SDRAM transaction.
    typedef struct packed {
        logic        active;
        logic        accepted;
        logic [1:0]  slot;
        logic [17:0] word;
        logic [21:0] sdram_word;
    } txn_t;

    logic [17:0] m_tag  [4];
    logic [15:0] m_data [4];
    logic [3:0]  m_valid;
    int          m_rr;
    txn_t        m_txn;
    logic        cmp_en = 1'b0;

    function automatic logic [21:0] off_of(input int s);
        case (s)
            0:       return OFF0;
            1:       return OFF1;
            2:       return OFF2;
            default: return OFF3;
        endcase
    endfunction

    function automatic logic model_hit(input int s);
        return cs_v[s] && m_valid[s] && (m_tag[s] == addr_v[s]);
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_rr    = 3;
        m_txn   = '0;
        for (int i = 0; i < 4; i++) begin
            m_tag[i]  = '0;
            m_data[i] = '0;
        end
    endtask

    // Advance the reference by one rising edge using the inputs held over it.
    task automatic model_step();
        if (downloading) begin
            m_valid       = '0;
            m_txn.active  = 1'b0;
            return;
        end
        if (!m_txn.active) begin
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (m_rr + k) % 4;
                if (!m_txn.active && cs_v[s] && !model_hit(s)) begin
                    m_txn.active     = 1'b1;
                    m_txn.accepted   = 1'b0;
                    m_txn.slot       = 2'(s);
                    m_txn.word       = addr_v[s];
                    m_txn.sdram_word = 22'((32'(off_of(s)) + 32'(addr_v[s])) % 32'h400000);
                end
            end
        end else if (!m_txn.accepted) begin
            if (sdram_ack) m_txn.accepted = 1'b1;
        end else if (data_rdy) begin
            m_data[m_txn.slot]  = data_read;
            m_tag[m_txn.slot]   = m_txn.word;
            m_valid[m_txn.slot] = 1'b1;
            m_rr                = int'(m_txn.slot);
            m_txn.active        = 1'b0;
        end
    endtask

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("sdram_req", 32'(sdram_req), 32'(m_txn.active && !m_txn.accepted));
            check("sdram_addr", 32'(sdram_addr), 32'(m_txn.sdram_word));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("slot%0d_ok", i), 32'(ok_v[i]), 32'(model_hit(i)));
                check($sformatf("slot%0d_dout", i), 32'(dout_v[i]), 32'(m_data[i]));
            end
        end
    end

    // ---------------- SDRAM controller stand-in ----------------
    int          ctl_phase = 0;
    int          ctl_cnt   = 0;
    int          ack_dly   = 1;
    int          rdy_dly   = 1;
    logic [15:0] rd_word   = 16'h0;
    logic        rdy_sent  = 1'b0;
    logic        rand_mode = 1'b0;

    task automatic ctl_drive();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        data_dst  = 1'b0;
        rdy_sent  = 1'b0;
        if (ctl_phase == 0 && sdram_req) begin
            ctl_phase = 1;
            ctl_cnt   = ack_dly;
        end
        if (ctl_phase == 1) begin
            if (ctl_cnt == 0) begin
                sdram_ack = 1'b1;
                ctl_phase = 2;
                ctl_cnt   = rdy_dly;
            end else begin
                ctl_cnt--;
            end
        end else if (ctl_phase == 2) begin
            if (ctl_cnt == 0) begin
                data_rdy  = 1'b1;
                data_read = rd_word;
                rdy_sent  = 1'b1;
                ctl_phase = 0;
            end else begin
                ctl_cnt--;
                if (ctl_cnt == 0) data_dst = 1'b1;
            end
        end else if (rand_mode && !sdram_req && $urandom_range(0, 29) == 0) begin
            // stray data_rdy while nothing is outstanding must be ignored
            data_rdy  = 1'b1;
            data_read = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        ctl_drive();
    endtask

    task automatic wait_req(output logic found);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            if (sdram_req) found = 1'b1;
        end
    endtask

    task automatic wait_req_low(output logic found);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            if (!sdram_req) found = 1'b1;
        end
    endtask

    task automatic wait_ok(input int s, output logic found);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            if (ok_v[s]) found = 1'b1;
        end
    endtask

    task automatic wait_rdy(output logic found);
        found = 1'b0;
        for (int n = 0; n < 80 && !found; n++) begin
            tick();
            if (rdy_sent) found = 1'b1;
        end
    endtask

    logic [21:0] grant_seq [4];
    int          grant_n;

    task automatic collect(input int n);
        logic prev;
        prev    = sdram_req;
        grant_n = 0;
        for (int i = 0; i < 4; i++) grant_seq[i] = '0;
        for (int c = 0; c < 400 && grant_n < n; c++) begin
            tick();
            if (sdram_req && !prev) begin
                grant_seq[grant_n] = sdram_addr;
                grant_n++;
            end
            prev = sdram_req;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic        found;
        logic        seen;
        logic [21:0] exp_rr [4];

        rst_n       = 1'b0;
        downloading = 1'b0;
        cs_v        = '0;
        for (int i = 0; i < 4; i++) addr_v[i] = '0;
        sdram_ack   = 1'b0;
        data_dst    = 1'b0;
        data_rdy    = 1'b0;
        data_read   = '0;
        model_reset();

        // reset state
        #3;
        check("rst_req", 32'(sdram_req), 32'd0);
        check("rst_addr", 32'(sdram_addr), 32'd0);
        check("rst_ok", 32'(ok_v), 32'd0);
        check("rst_dout0", 32'(dout_v[0]), 32'd0);
        check("rst_dout3", 32'(dout_v[3]), 32'd0);
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // single miss on slot 3
        tick();
        ack_dly   = 2;
        rdy_dly   = 2;
        rd_word   = 16'hBEEF;
        cs_v[3]   = 1'b1;
        addr_v[3] = 18'h00123;
        tick();
        #1;
        check("miss_req", 32'(sdram_req), 32'd1);
        check("miss_addr", 32'(sdram_addr), 32'h10123);
        wait_ok(3, found);
        check("miss_fill_done", 32'(found), 32'd1);
        #1;
        check("miss_dout", 32'(dout_v[3]), 32'hBEEF);

        // hit: same address again, no new request
        tick();
        cs_v[3] = 1'b0;
        tick();
        cs_v[3] = 1'b1;
        #1;
        check("hit_ok", 32'(ok_v[3]), 32'd1);
        check("hit_req", 32'(sdram_req), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | sdram_req;
        end
        check("hit_no_req", 32'(seen), 32'd0);

        // round robin: all four miss with rr=3
        rd_word   = 16'h1234;
        ack_dly   = 1;
        rdy_dly   = 1;
        cs_v      = 4'hF;
        addr_v[0] = 18'h00005;
        addr_v[1] = 18'h00007;
        addr_v[2] = 18'h10009;
        addr_v[3] = 18'h00011;
        exp_rr[0] = 22'h000005;
        exp_rr[1] = 22'h040007;
        exp_rr[2] = 22'h000009;   // 3F0000 + 10009 wraps in 22 bits
        exp_rr[3] = 22'h010011;
        collect(4);
        check("rr_count", 32'(grant_n), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), 32'(grant_seq[i]), 32'(exp_rr[i]));
        wait_ok(3, found);
        check("rr_last_fill", 32'(found), 32'd1);

        // serve slot 0 alone, then re-miss 0 and 2: 2 must win
        addr_v[0] = 18'h00020;
        wait_ok(0, found);
        check("rr0_fill", 32'(found), 32'd1);
        addr_v[0] = 18'h00021;
        addr_v[2] = 18'h1000A;
        collect(2);
        check("rr2_count", 32'(grant_n), 32'd2);
        check("rr2_first", 32'(grant_seq[0]), 32'h00000A);
        check("rr2_second", 32'(grant_seq[1]), 32'h000021);
        wait_ok(0, found);
        check("rr2_fill", 32'(found), 32'd1);

        // address change while waiting for data
        cs_v      = 4'b0001;
        ack_dly   = 0;
        rdy_dly   = 4;
        rd_word   = 16'h5A5A;
        addr_v[0] = 18'h00005;
        wait_req(found);
        check("chg_req_seen", 32'(found), 32'd1);
        check("chg_addr5", 32'(sdram_addr), 32'h000005);
        wait_req_low(found);
        check("chg_acked", 32'(found), 32'd1);
        addr_v[0] = 18'h00006;
        wait_rdy(found);
        check("chg_rdy_seen", 32'(found), 32'd1);
        tick();
        #1;
        check("chg_ok_low", 32'(ok_v[0]), 32'd0);
        check("chg_dout", 32'(dout_v[0]), 32'h5A5A);
        wait_req(found);
        check("chg_rereq", 32'(found), 32'd1);
        check("chg_addr6", 32'(sdram_addr), 32'h000006);
        wait_ok(0, found);
        check("chg_fill6", 32'(found), 32'd1);

        // download flush
        ack_dly   = 1;
        rdy_dly   = 1;
        cs_v      = 4'b0010;
        addr_v[1] = 18'h00007;
        #1;
        check("dl_hit_before", 32'(ok_v[1]), 32'd1);
        tick();
        downloading = 1'b1;
        tick();
        downloading = 1'b0;
        #1;
        check("dl_ok_low", 32'(ok_v[1]), 32'd0);
        check("dl_req_low", 32'(sdram_req), 32'd0);
        wait_req(found);
        check("dl_refetch", 32'(found), 32'd1);
        check("dl_refetch_addr", 32'(sdram_addr), 32'h040007);
        wait_ok(1, found);
        check("dl_refill", 32'(found), 32'd1);

        // asynchronous reset while a request is outstanding
        ack_dly   = 5;
        cs_v      = 4'b0100;
        addr_v[2] = 18'h00030;
        wait_req(found);
        check("ar_req_seen", 32'(found), 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        ctl_phase = 0;
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        #1;
        check("ar_req", 32'(sdram_req), 32'd0);
        check("ar_ok", 32'(ok_v), 32'd0);
        check("ar_dout1", 32'(dout_v[1]), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // randomized traffic checked every cycle against the reference
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) cs_v[i] = ~cs_v[i];
                if ($urandom_range(0, 9) == 0)
                    addr_v[i] = ($urandom_range(0, 4) == 0) ? 18'(18'h3FFFC + $urandom_range(0, 3))
                                                           : 18'($urandom_range(0, 3));
            end
            downloading = ($urandom_range(0, 149) == 0);
            ack_dly     = $urandom_range(0, 2);
            rdy_dly     = $urandom_range(0, 3);
            rd_word     = 16'($urandom);
        end
        cs_v        = '0;
        downloading = 1'b0;
        for (int n = 0; n < 20; n++) tick();

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
